// File: rtl/profile_snapshot_reader.sv
// Captures the profiler counters atomically and streams them as a framed word sequence
// (magic, info, counters, checksum) over valid/ready; also owns the profiler enable line.
module profile_snapshot_reader #(
    parameter int unsigned NUM_COUNTERS = 11,
    parameter logic [31:0] FRAME_MAGIC  = 32'hABAC_0001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       snapshot_req,
    input  logic                       clear_req,
    input  logic [NUM_COUNTERS*32-1:0] counters_flat,
    output logic                       profiler_enable,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic [15:0]                dropped_count
);

    localparam int unsigned     IDX_W    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_INFO,
        S_DATA,
        S_CSUM
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic [15:0]       seq_q, seq_d;
    logic [31:0]       buf_q [NUM_COUNTERS];
    logic [31:0]       buf_d [NUM_COUNTERS];
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic [15:0]       dropped_q, dropped_d;
    logic              enable_q, enable_d;
    logic              fire;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        buf_d       = buf_q;
        csum_d      = csum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dropped_d   = dropped_q;
        idx_inc     = idx_q + 1'b1;
        fire        = out_valid_q && out_ready;

        // A low enable already clears the profiler, so a second clear then is absorbed.
        enable_d = !(clear_req && enable_q);

        if (snapshot_req && (state_q != S_IDLE) && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (snapshot_req) begin
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        buf_d[i] = counters_flat[32*i +: 32];
                    end
                    csum_d      = '0;
                    out_data_d  = FRAME_MAGIC;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (fire) begin
                    csum_d     = csum_q ^ out_data_q;
                    out_data_d = {seq_q, 16'(NUM_COUNTERS)};
                    state_d    = S_INFO;
                end
            end
            S_INFO: begin
                if (fire) begin
                    csum_d     = csum_q ^ out_data_q;
                    out_data_d = buf_q[0];
                    idx_d      = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ out_data_q;
                    if (idx_q == LAST_IDX) begin
                        // The word leaving now still has to be folded into the checksum.
                        out_data_d = csum_q ^ out_data_q;
                        out_last_d = 1'b1;
                        state_d    = S_CSUM;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = buf_q[idx_inc];
                    end
                end
            end
            S_CSUM: begin
                if (fire) begin
                    out_data_d  = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    seq_d       = seq_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            seq_q       <= '0;
            csum_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= '0;
            enable_q    <= 1'b0;
            // NOTE: the snapshot buffer is small and must read as zero after reset, so it is reset.
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            csum_q      <= csum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            dropped_q   <= dropped_d;
            enable_q    <= enable_d;
            buf_q       <= buf_d;
        end
    end

    assign profiler_enable = enable_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign busy            = busy_q;
    assign dropped_count   = dropped_q;

endmodule

// File: tb/tb_profile_snapshot_reader.sv
// Bench for profile_snapshot_reader: a frame-queue model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_profile_snapshot_reader;

    localparam int N = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              snapshot_req = 1'b0;
    logic              clear_req = 1'b0;
    logic              out_ready = 1'b1;
    logic [N*32-1:0]   counters_flat = '0;
    logic              profiler_enable;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic [15:0]       dropped_count;

    profile_snapshot_reader #(.NUM_COUNTERS(N), .FRAME_MAGIC(32'hABAC_0001)) dut (
        .clk             (clk),
        .rst             (rst),
        .snapshot_req    (snapshot_req),
        .clear_req       (clear_req),
        .counters_flat   (counters_flat),
        .profiler_enable (profiler_enable),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .dropped_count   (dropped_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Model: a frame is a list of words; the stream shows its head until it is accepted.
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    logic [15:0] seq_m = '0;
    logic [15:0] drop_m = '0;
    logic        en_m = 1'b0;
    bit          model_on = 1'b0;
    int          hs_count = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        prev_stall = 1'b0;

    task automatic push_frame(input logic [N*32-1:0] cnt);
        logic [31:0] x;
        logic [31:0] w;
        x = 32'hABAC_0001;
        exp_q.push_back(32'hABAC_0001);
        w = {seq_m, 16'(N)};
        x = x ^ w;
        exp_q.push_back(w);
        for (int i = 0; i < N; i++) begin
            w = cnt[32*i +: 32];
            x = x ^ w;
            exp_q.push_back(w);
        end
        exp_q.push_back(x);
        seq_m = seq_m + 16'd1;
    endtask

    always @(negedge clk) begin
        bit frame_active;
        frame_active = (exp_q.size() != 0);
        if (model_on) begin
            check("valid", {31'b0, out_valid}, {31'b0, frame_active});
            check("busy", {31'b0, busy}, {31'b0, frame_active});
            check("dropped", {16'b0, dropped_count}, {16'b0, drop_m});
            check("enable", {31'b0, profiler_enable}, {31'b0, en_m});
            if (frame_active) begin
                check("data", out_data, exp_q[0]);
                check("last", {31'b0, out_last}, {31'b0, exp_q.size() == 1});
            end
            if (prev_stall && out_valid) begin
                check("stall_data", out_data, prev_data);
                check("stall_last", {31'b0, out_last}, {31'b0, prev_last});
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (!rst) begin
            exp_q.delete();
            seq_m      = '0;
            drop_m     = '0;
            en_m       = 1'b0;
            prev_stall = 1'b0;
            model_on   = 1'b1;
        end else begin
            if (snapshot_req && frame_active && drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
            if (frame_active && out_ready) begin
                got.push_back(out_data);
                hs_count++;
                void'(exp_q.pop_front());
            end
            if (snapshot_req && !frame_active) push_frame(counters_flat);
            en_m = !(clear_req && en_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            if (!busy && exp_q.size() == 0) return;
            tick();
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic set_counters(input logic [31:0] base);
        for (int i = 0; i < N; i++) counters_flat[32*i +: 32] = base + 32'(i);
    endtask

    task automatic snap();
        snapshot_req = 1'b1;
        tick();
        snapshot_req = 1'b0;
    endtask

    initial begin
        int hs0;
        set_counters(32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_data", out_data, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("en_after_rst", {31'b0, profiler_enable}, 32'h1);

        // Frame 1: basic frame, full throughput.
        got.delete();
        snap();
        check("first_valid", {31'b0, out_valid}, 32'h1);
        check("first_word", out_data, 32'hABAC_0001);
        wait_idle();
        check("f1_len", got.size(), 32'd14);
        if (got.size() == 14) begin
            check("f1_info", got[1], 32'h0000_000B);
            for (int i = 0; i < N; i++) check("f1_cnt", got[2+i], 32'(i + 1));
            check("f1_csum", got[13], 32'hABAC_000A);
        end

        // Frame 2: ready toggles every cycle.
        got.delete();
        snap();
        for (int c = 0; c < 80 && busy; c++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        check("f2_len", got.size(), 32'd14);
        if (got.size() == 14) begin
            check("f2_info", got[1], 32'h0001_000B);
            check("f2_csum", got[13], 32'hABAD_000A);
        end

        // Frame 3: counters move every cycle after capture.
        got.delete();
        set_counters(32'h100);
        snap();
        for (int c = 0; c < 20; c++) begin
            set_counters(32'h5000 + 32'(c * 16));
            tick();
        end
        wait_idle();
        check("f3_len", got.size(), 32'd14);
        if (got.size() == 14) begin
            check("f3_cnt0", got[2], 32'h100);
            check("f3_cnt10", got[12], 32'h10A);
        end

        // Frame 4: three snapshot pulses while busy.
        hs0 = hs_count;
        snap();
        tick();
        snap();
        tick();
        snap();
        tick();
        snap();
        wait_idle();
        repeat (3) tick();
        check("dropped_3", {16'b0, dropped_count}, 32'd3);
        check("one_frame", hs_count - hs0, 32'd14);

        // Frame 5: clear together with snapshot, then clears mid-frame.
        got.delete();
        set_counters(32'h200);
        snapshot_req = 1'b1;
        clear_req = 1'b1;
        tick();
        snapshot_req = 1'b0;
        clear_req = 1'b0;
        set_counters(32'h0);
        check("clr_en_low", {31'b0, profiler_enable}, 32'h0);
        tick();
        check("clr_en_back", {31'b0, profiler_enable}, 32'h1);
        clear_req = 1'b1;
        tick();
        tick();
        clear_req = 1'b0;
        check("clr_absorbed", {31'b0, profiler_enable}, 32'h1);
        wait_idle();
        check("f5_len", got.size(), 32'd14);
        if (got.size() == 14) check("f5_pre_clear", got[2], 32'h200);

        // Frame 6: reset during DATA word 5.
        set_counters(32'h200);
        snap();
        repeat (7) tick();
        check("at_data5", out_data, 32'h205);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_data", out_data, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_last", {31'b0, out_last}, 32'h0);
        check("mid_rst_drop", {16'b0, dropped_count}, 32'h0);
        check("mid_rst_en", {31'b0, profiler_enable}, 32'h0);
        tick();
        check("no_partial", {31'b0, out_valid}, 32'h0);
        got.delete();
        snap();
        wait_idle();
        check("f6_len", got.size(), 32'd14);
        if (got.size() == 14) check("f6_seq0", got[1], 32'h0000_000B);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
